// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter that shares a dual-address, single-read-enable memory reader between
// NUM_REQ requesters. Define MEM_READ_ARB_MERGE_EN to also serve same-address requests on port 1.
module mem_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*DW-1:0] rsp_data,
  output logic                  mem_rden,
  output logic [AW-1:0]         mem_addr1,
  output logic [AW-1:0]         mem_addr2,
  input  logic [DW-1:0]         mem_dout1,
  input  logic [DW-1:0]         mem_dout2
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_ptr_nxt;
  logic [AW-1:0]      addr_arr [NUM_REQ];

  logic               found_a;
  logic               found_b;
  logic [PW-1:0]      id_a;
  logic [PW-1:0]      id_b;
  logic [PW-1:0]      last_id;
  logic [PW-1:0]      idx;
  logic [NUM_REQ-1:0] grant1;
  logic [NUM_REQ-1:0] grant2;

  // Per-port owner masks for the read issued in the previous cycle.
  logic [NUM_REQ-1:0] own1;
  logic [NUM_REQ-1:0] own2;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
    end
  end

  // Scan in round-robin order from rr_ptr; last_id ends at the latest-scanned grant.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    id_a    = '0;
    id_b    = '0;
    last_id = '0;
    idx     = '0;
    grant1  = '0;
    grant2  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        if (!found_a) begin
          found_a      = 1'b1;
          id_a         = idx;
          last_id      = idx;
          grant1[idx]  = 1'b1;
        end
`ifdef MEM_READ_ARB_MERGE_EN
        else if (addr_arr[idx] == addr_arr[id_a]) begin
          grant1[idx]  = 1'b1;
          last_id      = idx;
        end
`endif
        else if (!found_b) begin
          found_b      = 1'b1;
          id_b         = idx;
          last_id      = idx;
          grant2[idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mem_rden  = 1'b0;
    mem_addr1 = '0;
    mem_addr2 = '0;
    if (!rst) begin
      req_ready = grant1 | grant2;
      mem_rden  = found_a;
      if (found_a) mem_addr1 = addr_arr[id_a];
      if (found_b) mem_addr2 = addr_arr[id_b];
    end
  end

  always_comb begin
    rr_ptr_nxt = last_id + 1'b1;
    if (last_id == PW'(NUM_REQ-1)) rr_ptr_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found_a) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef MEM_READ_ARB_MERGE_EN
  logic [NUM_REQ-1:0] s_mask1;
  logic [NUM_REQ-1:0] s_mask2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_mask1 <= '0;
      s_mask2 <= '0;
    end else begin
      s_mask1 <= grant1;
      s_mask2 <= grant2;
    end
  end

  always_comb begin
    own1 = s_mask1;
    own2 = s_mask2;
  end
`else
  logic          s_valid1;
  logic          s_valid2;
  logic [PW-1:0] s_id1;
  logic [PW-1:0] s_id2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid1 <= 1'b0;
      s_valid2 <= 1'b0;
      s_id1    <= '0;
      s_id2    <= '0;
    end else begin
      s_valid1 <= found_a;
      s_valid2 <= found_b;
      s_id1    <= id_a;
      s_id2    <= id_b;
    end
  end

  always_comb begin
    own1 = '0;
    own2 = '0;
    if (s_valid1) own1[s_id1] = 1'b1;
    if (s_valid2) own2[s_id2] = 1'b1;
  end
`endif

  // Responses are dropped combinationally while reset is held.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] = own1[i] | own2[i];
        if (own1[i]) begin
          rsp_data[i*DW +: DW] = mem_dout1;
        end else if (own2[i]) begin
          rsp_data[i*DW +: DW] = mem_dout2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed vectors, corner sequences and a
// randomized run against a queue-based round-robin reference model.
module tb_mem_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic            mem_rden;
  logic [AW-1:0]   mem_addr1;
  logic [AW-1:0]   mem_addr2;
  logic [DW-1:0]   mem_dout1 = '0;
  logic [DW-1:0]   mem_dout2 = '0;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]  cur_v;
  logic [AW-1:0] cur_a [N];

  always #5 clk = ~clk;

  mem_read_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_rden(mem_rden), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Synchronous memory reader model.
  always @(posedge clk) begin
    if (mem_rden) begin
      mem_dout1 <= memf(mem_addr1);
      mem_dout2 <= memf(mem_addr2);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive();
    req_valid = cur_v;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = cur_a[i];
  endtask

  task automatic set_req(input logic [3:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
    cur_v = v;
    cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2; cur_a[3] = a3;
    drive();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  ready;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [3:0]  rsp;
  } vec_t;

  vec_t          tbl [10];
  logic [31:0]   taddr [N];
  logic [127:0]  exp_data;

  // reference model state
  int            ptr;
  logic [3:0]    pend_mask;
  logic [127:0]  pend_data;
  logic [3:0]    g_mask;
  logic [127:0]  g_data;
  int            order[$];
  int            same[$];
  int            diff[$];
  int            b_id;
  int            far_pos;
  int            pos;
  logic [31:0]   e_a1;
  logic [31:0]   e_a2;

  initial begin
    taddr[0] = 32'h100; taddr[1] = 32'h10; taddr[2] = 32'h200; taddr[3] = 32'h300;
    tbl[0] = '{v:4'b0010, ready:4'b0010, a1:32'h10,  a2:32'h0,   rsp:4'b0000};
    tbl[1] = '{v:4'b1111, ready:4'b1100, a1:32'h200, a2:32'h300, rsp:4'b0010};
    tbl[2] = '{v:4'b1111, ready:4'b0011, a1:32'h100, a2:32'h10,  rsp:4'b1100};
    tbl[3] = '{v:4'b1111, ready:4'b1100, a1:32'h200, a2:32'h300, rsp:4'b0011};
    tbl[4] = '{v:4'b1001, ready:4'b1001, a1:32'h100, a2:32'h300, rsp:4'b1100};
    tbl[5] = '{v:4'b0000, ready:4'b0000, a1:32'h0,   a2:32'h0,   rsp:4'b1001};
    tbl[6] = '{v:4'b0100, ready:4'b0100, a1:32'h200, a2:32'h0,   rsp:4'b0000};
    tbl[7] = '{v:4'b1001, ready:4'b1001, a1:32'h300, a2:32'h100, rsp:4'b0100};
    tbl[8] = '{v:4'b0101, ready:4'b0101, a1:32'h200, a2:32'h100, rsp:4'b1001};
    tbl[9] = '{v:4'b0010, ready:4'b0010, a1:32'h10,  a2:32'h0,   rsp:4'b0101};

    // Reset holds everything quiet even with all requesters pending.
    rst = 1'b1;
    set_req(4'hF, 32'h100, 32'h10, 32'h200, 32'h300);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_ready", 128'(req_ready), 128'(0));
      chk("rst_rden", 128'(mem_rden), 128'(0));
      chk("rst_addr1", 128'(mem_addr1), 128'(0));
      chk("rst_addr2", 128'(mem_addr2), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_data", 128'(rsp_data), 128'(0));
    end

    // Grant req2, then reset in the response cycle: response dropped, pointer back to 0.
    @(negedge clk); rst = 1'b0;
    set_req(4'b0100, 32'h100, 32'h10, 32'h200, 32'h300); #1;
    chk("midrst_grant", 128'(req_ready), 128'(4'b0100));
    chk("midrst_addr1", 128'(mem_addr1), 128'(32'h200));
    @(negedge clk); rst = 1'b1; set_req(4'b0000, 32'h100, 32'h10, 32'h200, 32'h300); #1;
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("midrst_rsp_data", 128'(rsp_data), 128'(0));
    @(negedge clk); rst = 1'b0; set_req(4'hF, 32'h100, 32'h10, 32'h200, 32'h300); #1;
    chk("post_rst_ready", 128'(req_ready), 128'(4'b0011));
    chk("post_rst_addr1", 128'(mem_addr1), 128'(32'h100));
    chk("post_rst_addr2", 128'(mem_addr2), 128'(32'h10));
    chk("post_rst_no_stale_rsp", 128'(rsp_valid), 128'(0));

    // Directed vectors from a freshly reset pointer.
    @(negedge clk); rst = 1'b1; set_req(4'b0000, 32'h100, 32'h10, 32'h200, 32'h300);
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 10; r++) begin
      set_req(tbl[r].v, taddr[0], taddr[1], taddr[2], taddr[3]); #1;
      exp_data = '0;
      for (int i = 0; i < N; i++) if (tbl[r].rsp[i]) exp_data[i*DW +: DW] = memf(taddr[i]);
      chk($sformatf("tbl%0d_ready", r), 128'(req_ready), 128'(tbl[r].ready));
      chk($sformatf("tbl%0d_rden", r), 128'(mem_rden), 128'(tbl[r].ready != 4'b0));
      chk($sformatf("tbl%0d_addr1", r), 128'(mem_addr1), 128'(tbl[r].a1));
      chk($sformatf("tbl%0d_addr2", r), 128'(mem_addr2), 128'(tbl[r].a2));
      chk($sformatf("tbl%0d_rsp_valid", r), 128'(rsp_valid), 128'(tbl[r].rsp));
      chk($sformatf("tbl%0d_rsp_data", r), 128'(rsp_data), exp_data);
      @(negedge clk);
    end

    // Duplicate-address requesters.
    rst = 1'b1; set_req(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
    set_req(4'b0111, 32'h40, 32'h44, 32'h40, 32'h0); #1;
`ifdef MEM_READ_ARB_MERGE_EN
    chk("merge_ready", 128'(req_ready), 128'(4'b0111));
    chk("merge_addr1", 128'(mem_addr1), 128'(32'h40));
    chk("merge_addr2", 128'(mem_addr2), 128'(32'h44));
    @(negedge clk); set_req(4'b0000, 32'h40, 32'h44, 32'h40, 32'h0); #1;
    chk("merge_rsp_valid", 128'(rsp_valid), 128'(4'b0111));
    chk("merge_rsp_data", 128'(rsp_data),
        {32'h0, memf(32'h40), memf(32'h44), memf(32'h40)});
`else
    chk("dup_ready0", 128'(req_ready), 128'(4'b0011));
    chk("dup_addr1_0", 128'(mem_addr1), 128'(32'h40));
    chk("dup_addr2_0", 128'(mem_addr2), 128'(32'h44));
    @(negedge clk); set_req(4'b0100, 32'h40, 32'h44, 32'h40, 32'h0); #1;
    chk("dup_ready1", 128'(req_ready), 128'(4'b0100));
    chk("dup_addr1_1", 128'(mem_addr1), 128'(32'h40));
    chk("dup_addr2_1", 128'(mem_addr2), 128'(32'h0));
    chk("dup_rsp_valid", 128'(rsp_valid), 128'(4'b0011));
    chk("dup_rsp_data", 128'(rsp_data), {64'h0, memf(32'h44), memf(32'h40)});
`endif

    // Randomized run against the reference model.
    @(negedge clk); rst = 1'b1; set_req(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    ptr = 0; pend_mask = '0; pend_data = '0; g_mask = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(cur_v[i] && !g_mask[i])) begin
          cur_v[i] = ($urandom_range(0, 99) < 60);
          case ($urandom_range(0, 3))
            0: cur_a[i] = 32'h40;
            1: cur_a[i] = 32'h44;
            2: cur_a[i] = 32'h10;
            default: cur_a[i] = 32'h80;
          endcase
        end
      end
      drive(); #1;

      g_mask = '0; g_data = '0; e_a1 = '0; e_a2 = '0; b_id = -1; far_pos = -1;
      order = {}; same = {}; diff = {};
      if (!rst) begin
        for (int k = 0; k < N; k++) if (cur_v[(ptr + k) % N]) order.push_back((ptr + k) % N);
        if (order.size() > 0) begin
          same.push_back(order[0]);
          for (int j = 1; j < order.size(); j++) begin
`ifdef MEM_READ_ARB_MERGE_EN
            if (cur_a[order[j]] == cur_a[order[0]]) same.push_back(order[j]);
            else diff.push_back(order[j]);
`else
            diff.push_back(order[j]);
`endif
          end
          e_a1 = cur_a[order[0]];
          if (diff.size() > 0) begin b_id = diff[0]; e_a2 = cur_a[b_id]; end
          foreach (same[j]) g_mask[same[j]] = 1'b1;
          if (b_id >= 0) g_mask[b_id] = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (g_mask[i]) begin
              g_data[i*DW +: DW] = memf(cur_a[i]);
              pos = (i - ptr + N) % N;
              if (pos > far_pos) far_pos = pos;
            end
          end
        end
      end

      chk("rnd_ready", 128'(req_ready), 128'(g_mask));
      chk("rnd_rden", 128'(mem_rden), 128'(g_mask != 4'b0));
      chk("rnd_addr1", 128'(mem_addr1), 128'(e_a1));
      chk("rnd_addr2", 128'(mem_addr2), 128'(e_a2));
      chk("rnd_rsp_valid", 128'(rsp_valid), rst ? 128'(0) : 128'(pend_mask));
      chk("rnd_rsp_data", 128'(rsp_data), rst ? 128'(0) : pend_data);

      if (rst) begin
        ptr = 0; pend_mask = '0; pend_data = '0;
      end else begin
        if (far_pos >= 0) ptr = (ptr + far_pos + 1) % N;
        pend_mask = g_mask; pend_data = g_data;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
